// File: rtl/rt_ibex_window_ctrl_pkg.sv
// Shared types and helpers for the rt-ibex register-window sequencer.
// The EABI index map is also used by the window file's register decoder.
package rt_ibex_window_pkg;

  localparam int unsigned FrameWords = 9;
  localparam int unsigned EabiRegs   = 7;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    SPILL_REQ  = 3'd1,
    SPILL_WAIT = 3'd2,
    FILL_REQ   = 3'd3,
    FILL_WAIT  = 3'd4,
    DONE       = 3'd5
  } win_state_e;

  // What the DONE cycle has to finish off.
  typedef enum logic [2:0] {
    OP_ENTRY_INC   = 3'd0,
    OP_ENTRY_SPILL = 3'd1,
    OP_ENTRY_OVF   = 3'd2,
    OP_EXIT_DEC    = 3'd3,
    OP_EXIT_FILL   = 3'd4,
    OP_EXIT_UNF    = 3'd5
  } win_op_e;

  // Frame word index -> architectural register index (x1, x5, x10..x13, x15).
  function automatic logic [4:0] eabi_reg_idx(input logic [3:0] k);
    logic [4:0] idx;
    case (k)
      4'd0:    idx = 5'd1;
      4'd1:    idx = 5'd5;
      4'd2:    idx = 5'd10;
      4'd3:    idx = 5'd11;
      4'd4:    idx = 5'd12;
      4'd5:    idx = 5'd13;
      4'd6:    idx = 5'd15;
      default: idx = 5'd0;
    endcase
    return idx;
  endfunction

endpackage

// File: rtl/rt_ibex_window_ctrl_if.sv
// Single-outstanding data-bus link between the window sequencer and the
// LSU-side arbiter. The sequencer is the master.
interface rt_ibex_window_ctrl_if;
  logic        data_req;
  logic        data_gnt;
  logic        data_rvalid;
  logic        data_we;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_we, data_addr, data_wdata,
    input  data_gnt, data_rvalid, data_rdata
  );

  modport slave (
    input  data_req, data_we, data_addr, data_wdata,
    output data_gnt, data_rvalid, data_rdata
  );
endinterface

// File: rtl/rt_ibex_window_ctrl.sv
// Register-window sequencer: turns interrupt entry / mret into window pointer
// moves, and spills/refills the top window to a memory stack when the
// hardware windows are exhausted.
module rt_ibex_window_ctrl
  import rt_ibex_window_pkg::*;
#(
  parameter int unsigned NumRegisterWindows = 4,
  parameter int unsigned WindowSize         = 7,
  parameter logic [31:0] SpillBase          = 32'h0000_F000,
  parameter int unsigned MaxSpillDepth      = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        entry_req_i,
  output logic        entry_ack_o,
  input  logic        exit_req_i,
  output logic        exit_ack_o,
  output logic        increment_ptr_o,
  output logic        decrement_ptr_o,
  output logic        save_csr_o,
  output logic [4:0]  spill_raddr_o,
  input  logic [31:0] spill_rdata_i,
  input  logic [31:0] mcause_i,
  input  logic [31:0] mepc_i,
  output logic        fill_we_o,
  output logic [4:0]  fill_waddr_o,
  output logic [31:0] fill_wdata_o,
  output logic        fill_csr_we_o,
  output logic [31:0] fill_mcause_o,
  output logic [31:0] fill_mepc_o,
  rt_ibex_window_ctrl_if.master bus,
  output logic        busy_o,
  output logic        overflow_err_o
);

  localparam int unsigned HwW = (NumRegisterWindows > 1) ? $clog2(NumRegisterWindows) : 1;
  localparam int unsigned SpW = $clog2(MaxSpillDepth + 1);

  localparam logic [HwW-1:0] HwMax   = HwW'(NumRegisterWindows - 1);
  localparam logic [HwW-1:0] HwOne   = HwW'(32'd1);
  localparam logic [SpW-1:0] SpMax   = SpW'(MaxSpillDepth);
  localparam logic [SpW-1:0] SpOne   = SpW'(32'd1);
  localparam logic [3:0]     KRegs   = 4'(WindowSize);
  localparam logic [3:0]     KMcause = 4'(WindowSize);
  localparam logic [3:0]     KMepc   = 4'(FrameWords - 1);

  win_state_e     state_r, state_next_s;
  win_op_e        op_r, op_next_s;
  logic [3:0]     k_r, k_next_s;
  logic [HwW-1:0] hw_depth_r;
  logic [SpW-1:0] spill_depth_r;
  logic [31:0]    mcause_r;
  logic           ovf_set_s;
  logic           overflow_r;
  logic           entry_ack_r, exit_ack_r, inc_r, dec_r, save_r, busy_r;

  logic [SpW-1:0] slot_s;
  logic [31:0]    frame_addr_s;
  logic           req_s, we_s;
  logic [31:0]    addr_s, wdata_s;
  logic [4:0]     raddr_s;
  logic           fill_we_s, fill_csr_we_s;
  logic [4:0]     fill_waddr_s;
  logic [31:0]    fill_wdata_s, fill_mcause_s, fill_mepc_s;

  // Next-state decision: request arbitration in IDLE and bus-word sequencing.
  always_comb begin
    state_next_s = state_r;
    op_next_s    = op_r;
    k_next_s     = k_r;
    ovf_set_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (entry_req_i) begin
          if (hw_depth_r < HwMax) begin
            op_next_s    = OP_ENTRY_INC;
            state_next_s = DONE;
          end else if (spill_depth_r < SpMax) begin
            op_next_s    = OP_ENTRY_SPILL;
            state_next_s = SPILL_REQ;
            k_next_s     = 4'd0;
          end else begin
            op_next_s    = OP_ENTRY_OVF;
            state_next_s = DONE;
            ovf_set_s    = 1'b1;
          end
        end else if (exit_req_i) begin
          if (spill_depth_r != {SpW{1'b0}}) begin
            op_next_s    = OP_EXIT_FILL;
            state_next_s = FILL_REQ;
            k_next_s     = 4'd0;
          end else if (hw_depth_r != {HwW{1'b0}}) begin
            op_next_s    = OP_EXIT_DEC;
            state_next_s = DONE;
          end else begin
            op_next_s    = OP_EXIT_UNF;
            state_next_s = DONE;
            ovf_set_s    = 1'b1;
          end
        end else begin
          state_next_s = IDLE;
        end
      end
      SPILL_REQ: begin
        if (bus.data_gnt) state_next_s = SPILL_WAIT;
        else              state_next_s = SPILL_REQ;
      end
      SPILL_WAIT: begin
        if (bus.data_rvalid) begin
          if (k_r == KMepc) begin
            state_next_s = DONE;
          end else begin
            k_next_s     = k_r + 4'd1;
            state_next_s = SPILL_REQ;
          end
        end else begin
          state_next_s = SPILL_WAIT;
        end
      end
      FILL_REQ: begin
        if (bus.data_gnt) state_next_s = FILL_WAIT;
        else              state_next_s = FILL_REQ;
      end
      FILL_WAIT: begin
        if (bus.data_rvalid) begin
          if (k_r == KMepc) begin
            state_next_s = DONE;
          end else begin
            k_next_s     = k_r + 4'd1;
            state_next_s = FILL_REQ;
          end
        end else begin
          state_next_s = FILL_WAIT;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state, pending operation and frame word index.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
      op_r    <= OP_ENTRY_INC;
      k_r     <= 4'd0;
    end else begin
      state_r <= state_next_s;
      op_r    <= op_next_s;
      k_r     <= k_next_s;
    end
  end

  // Depth counters move in the DONE cycle, once the operation is complete.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hw_depth_r    <= {HwW{1'b0}};
      spill_depth_r <= {SpW{1'b0}};
    end else if (state_r == DONE) begin
      case (op_r)
        OP_ENTRY_INC:   hw_depth_r    <= hw_depth_r + HwOne;
        OP_EXIT_DEC:    hw_depth_r    <= hw_depth_r - HwOne;
        OP_ENTRY_SPILL: spill_depth_r <= spill_depth_r + SpOne;
        OP_EXIT_FILL:   spill_depth_r <= spill_depth_r - SpOne;
        default: begin
          hw_depth_r    <= hw_depth_r;
          spill_depth_r <= spill_depth_r;
        end
      endcase
    end
  end

  // Hold the refilled mcause word until mepc arrives so both CSRs load together.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mcause_r <= 32'd0;
    end else if (state_r == FILL_WAIT && bus.data_rvalid && k_r == KMcause) begin
      mcause_r <= bus.data_rdata;
    end
  end

  // Acks and window strobes are registered one-cycle pulses aligned with DONE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      entry_ack_r <= 1'b0;
      exit_ack_r  <= 1'b0;
      inc_r       <= 1'b0;
      dec_r       <= 1'b0;
      save_r      <= 1'b0;
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
    end else begin
      entry_ack_r <= (state_next_s == DONE) &&
                     (op_next_s inside {OP_ENTRY_INC, OP_ENTRY_SPILL, OP_ENTRY_OVF});
      save_r      <= (state_next_s == DONE) &&
                     (op_next_s inside {OP_ENTRY_INC, OP_ENTRY_SPILL, OP_ENTRY_OVF});
      exit_ack_r  <= (state_next_s == DONE) &&
                     (op_next_s inside {OP_EXIT_DEC, OP_EXIT_FILL, OP_EXIT_UNF});
      inc_r       <= (state_next_s == DONE) && (op_next_s == OP_ENTRY_INC);
      dec_r       <= (state_next_s == DONE) && (op_next_s == OP_EXIT_DEC);
      busy_r      <= (state_next_s != IDLE);
      overflow_r  <= overflow_r | ovf_set_s;
    end
  end

  // Frame address: the spill slot is the current depth, a fill reads the one below.
  always_comb begin
    if (state_r == FILL_REQ || state_r == FILL_WAIT) begin
      slot_s = spill_depth_r - SpOne;
    end else begin
      slot_s = spill_depth_r;
    end
    frame_addr_s = SpillBase + (32'(slot_s) * 32'd36) + (32'(k_r) * 32'd4);
  end

  // Bus request and refill port drive, decoded from the current state and word.
  always_comb begin
    req_s         = 1'b0;
    we_s          = 1'b0;
    addr_s        = 32'd0;
    wdata_s       = 32'd0;
    raddr_s       = 5'd0;
    fill_we_s     = 1'b0;
    fill_waddr_s  = 5'd0;
    fill_wdata_s  = 32'd0;
    fill_csr_we_s = 1'b0;
    fill_mcause_s = 32'd0;
    fill_mepc_s   = 32'd0;
    case (state_r)
      SPILL_REQ: begin
        req_s   = 1'b1;
        we_s    = 1'b1;
        addr_s  = frame_addr_s;
        raddr_s = eabi_reg_idx(k_r);
        if (k_r < KRegs)          wdata_s = spill_rdata_i;
        else if (k_r == KMcause)  wdata_s = mcause_i;
        else                      wdata_s = mepc_i;
      end
      FILL_REQ: begin
        req_s  = 1'b1;
        addr_s = frame_addr_s;
      end
      FILL_WAIT: begin
        if (bus.data_rvalid) begin
          if (k_r < KRegs) begin
            fill_we_s    = 1'b1;
            fill_waddr_s = eabi_reg_idx(k_r);
            fill_wdata_s = bus.data_rdata;
          end else if (k_r == KMepc) begin
            fill_csr_we_s = 1'b1;
            fill_mcause_s = mcause_r;
            fill_mepc_s   = bus.data_rdata;
          end else begin
            fill_we_s = 1'b0;
          end
        end else begin
          fill_we_s = 1'b0;
        end
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  assign bus.data_req    = req_s;
  assign bus.data_we     = we_s;
  assign bus.data_addr   = addr_s;
  assign bus.data_wdata  = wdata_s;
  assign spill_raddr_o   = raddr_s;
  assign fill_we_o       = fill_we_s;
  assign fill_waddr_o    = fill_waddr_s;
  assign fill_wdata_o    = fill_wdata_s;
  assign fill_csr_we_o   = fill_csr_we_s;
  assign fill_mcause_o   = fill_mcause_s;
  assign fill_mepc_o     = fill_mepc_s;
  assign entry_ack_o     = entry_ack_r;
  assign exit_ack_o      = exit_ack_r;
  assign increment_ptr_o = inc_r;
  assign decrement_ptr_o = dec_r;
  assign save_csr_o      = save_r;
  assign busy_o          = busy_r;
  assign overflow_err_o  = overflow_r;

endmodule

// File: tb/tb_rt_ibex_window_ctrl.sv
// Directed bench for rt_ibex_window_ctrl with a small memory-backed bus slave.
module tb_rt_ibex_window_ctrl;

  logic        clk, rst;
  logic        entry_req, entry_ack, exit_req, exit_ack;
  logic        inc_ptr, dec_ptr, save_csr;
  logic [4:0]  spill_raddr;
  logic [31:0] spill_rdata, mcause, mepc;
  logic        fill_we, fill_csr_we;
  logic [4:0]  fill_waddr;
  logic [31:0] fill_wdata, fill_mcause, fill_mepc;
  logic        busy, overflow_err;

  rt_ibex_window_ctrl_if bus ();

  rt_ibex_window_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .entry_req_i     (entry_req),
    .entry_ack_o     (entry_ack),
    .exit_req_i      (exit_req),
    .exit_ack_o      (exit_ack),
    .increment_ptr_o (inc_ptr),
    .decrement_ptr_o (dec_ptr),
    .save_csr_o      (save_csr),
    .spill_raddr_o   (spill_raddr),
    .spill_rdata_i   (spill_rdata),
    .mcause_i        (mcause),
    .mepc_i          (mepc),
    .fill_we_o       (fill_we),
    .fill_waddr_o    (fill_waddr),
    .fill_wdata_o    (fill_wdata),
    .fill_csr_we_o   (fill_csr_we),
    .fill_mcause_o   (fill_mcause),
    .fill_mepc_o     (fill_mepc),
    .bus             (bus.master),
    .busy_o          (busy),
    .overflow_err_o  (overflow_err)
  );

  // Register-file read model: value encodes the register index.
  assign spill_rdata = 32'hCAFE_0000 | {27'd0, spill_raddr};

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0, lat, n_inc, n_dec, n_save, n_both, n_xack;
  bit stall_en = 1'b0;
  int regs [7] = '{1, 5, 10, 11, 12, 13, 15};

  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr_q[$], wr_data_q[$], rd_addr_q[$];
  int          wr_cyc_q[$];
  logic [4:0]  fw_addr_q[$];
  logic [31:0] fw_data_q[$];
  int          csr_cnt;
  logic [31:0] csr_mcause, csr_mepc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
    end
  end

  // Bus slave: optional grant/rvalid stalls, stores writes, returns memory on reads.
  initial begin
    logic [31:0] a, d;
    logic        w;
    int          st, gd, rd;
    bus.data_gnt    = 1'b0;
    bus.data_rvalid = 1'b0;
    bus.data_rdata  = 32'd0;
    forever begin
      @(negedge clk);
      while (bus.data_req === 1'b1) begin
        a  = bus.data_addr;
        w  = bus.data_we;
        d  = bus.data_wdata;
        st = cyc;
        gd = stall_en ? int'($urandom_range(0, 3)) : 0;
        for (int i = 0; i < gd; i++) begin
          @(negedge clk);
          check_eq("stall_addr_stable",  {32'd0, bus.data_addr},  {32'd0, a});
          check_eq("stall_wdata_stable", {32'd0, bus.data_wdata}, {32'd0, d});
          check_eq("stall_we_stable",    {63'd0, bus.data_we},    {63'd0, w});
        end
        bus.data_gnt = 1'b1;
        @(negedge clk);
        bus.data_gnt = 1'b0;
        rd = stall_en ? int'($urandom_range(0, 2)) : 0;
        repeat (rd) @(negedge clk);
        if (w) begin
          mem[a] = d;
          wr_addr_q.push_back(a);
          wr_data_q.push_back(d);
          wr_cyc_q.push_back(st);
        end else begin
          rd_addr_q.push_back(a);
          bus.data_rdata = mem.exists(a) ? mem[a] : 32'd0;
        end
        bus.data_rvalid = 1'b1;
        #1;
        if (!w && fill_we) begin
          fw_addr_q.push_back(fill_waddr);
          fw_data_q.push_back(fill_wdata);
        end
        if (!w && fill_csr_we) begin
          csr_cnt++;
          csr_mcause = fill_mcause;
          csr_mepc   = fill_mepc;
        end
        @(negedge clk);
        bus.data_rvalid = 1'b0;
      end
    end
  end

  // Raise a request, count strobes per cycle until its ack, then sit out the ack cycle.
  task automatic do_req(input logic ent, input logic ext, input string tag);
    logic got_ack;
    @(negedge clk);
    entry_req = ent;
    exit_req  = ext;
    t0 = cyc;
    lat = 0; n_inc = 0; n_dec = 0; n_save = 0; n_both = 0; n_xack = 0;
    got_ack = 1'b0;
    for (int n = 1; n <= 200 && !got_ack; n++) begin
      @(posedge clk);
      #1;
      if (inc_ptr)            n_inc++;
      if (dec_ptr)            n_dec++;
      if (save_csr)           n_save++;
      if (inc_ptr && dec_ptr) n_both++;
      if (ent && exit_ack)    n_xack++;
      if (ent ? entry_ack : exit_ack) begin
        got_ack = 1'b1;
        lat = n;
      end
    end
    if (ent) entry_req = 1'b0;
    else     exit_req  = 1'b0;
    if (!got_ack) check_eq({tag, "_timeout"}, 64'd0, 64'd1);
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete(); rd_addr_q.delete();
    fw_addr_q.delete(); fw_data_q.delete();
    csr_cnt = 0; csr_mcause = 32'd0; csr_mepc = 32'd0;
  endtask

  initial begin
    logic found;
    logic [31:0] exp_addr;
    rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0;
    mcause = 32'd0; mepc = 32'd0;
    clear_logs();

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_strobes", {57'd0, entry_ack, exit_ack, inc_ptr, dec_ptr, save_csr, fill_we, fill_csr_we}, 64'd0);
    check_eq("rst_bus", {31'd0, bus.data_req, bus.data_addr}, 64'd0);
    check_eq("rst_ovf", {63'd0, overflow_err}, 64'd0);
    rst = 1'b0;

    // Three simple entries, then three simple exits
    for (int i = 0; i < 3; i++) begin
      do_req(1'b1, 1'b0, "entry");
      check_eq($sformatf("entry%0d_lat", i), 64'(lat), 64'd1);
      check_eq($sformatf("entry%0d_inc", i), 64'(n_inc), 64'd1);
      check_eq($sformatf("entry%0d_save", i), 64'(n_save), 64'd1);
    end
    for (int i = 0; i < 3; i++) begin
      do_req(1'b0, 1'b1, "exit");
      check_eq($sformatf("exit%0d_lat", i), 64'(lat), 64'd1);
      check_eq($sformatf("exit%0d_dec", i), 64'(n_dec), 64'd1);
      check_eq($sformatf("exit%0d_inc", i), 64'(n_inc), 64'd0);
    end

    // Underflow: exit with both counters at zero
    clear_logs();
    do_req(1'b0, 1'b1, "underflow");
    check_eq("unf_lat", 64'(lat), 64'd1);
    check_eq("unf_dec", 64'(n_dec), 64'd0);
    check_eq("unf_ovf", {63'd0, overflow_err}, 64'd1);
    check_eq("unf_no_bus", 64'(rd_addr_q.size()), 64'd0);

    // Reset clears the sticky flag
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    #1;
    check_eq("rst_clears_ovf", {63'd0, overflow_err}, 64'd0);

    // Fill the hardware windows, then spill on the 4th entry
    for (int i = 0; i < 3; i++) do_req(1'b1, 1'b0, "pre_spill");
    mcause = 32'h8000_0007; mepc = 32'h0000_0100;
    clear_logs();
    do_req(1'b1, 1'b0, "spill");
    check_eq("spill_lat", 64'(lat), 64'd19);
    check_eq("spill_inc", 64'(n_inc), 64'd0);
    check_eq("spill_save", 64'(n_save), 64'd1);
    check_eq("spill_excl", 64'(n_both), 64'd0);
    check_eq("spill_nwr", 64'(wr_addr_q.size()), 64'd9);
    for (int k = 0; k < 9 && k < wr_addr_q.size(); k++) begin
      check_eq($sformatf("spill_addr_k%0d", k), {32'd0, wr_addr_q[k]}, 64'(32'h0000_F000 + 32'(4 * k)));
      check_eq($sformatf("spill_cyc_k%0d", k), 64'(wr_cyc_q[k] - t0), 64'(1 + 2 * k));
      if (k < 7)
        check_eq($sformatf("spill_data_k%0d", k), {32'd0, wr_data_q[k]}, 64'(32'hCAFE_0000 | 32'(regs[k])));
      else if (k == 7)
        check_eq("spill_data_mcause", {32'd0, wr_data_q[k]}, 64'h8000_0007);
      else
        check_eq("spill_data_mepc", {32'd0, wr_data_q[k]}, 64'h0000_0100);
    end

    // Refill that frame on the next exit
    mcause = 32'd0; mepc = 32'd0;
    clear_logs();
    do_req(1'b0, 1'b1, "fill");
    check_eq("fill_lat", 64'(lat), 64'd19);
    check_eq("fill_dec", 64'(n_dec), 64'd0);
    check_eq("fill_nwe", 64'(fw_addr_q.size()), 64'd7);
    for (int k = 0; k < 7 && k < fw_addr_q.size(); k++) begin
      check_eq($sformatf("fill_waddr_k%0d", k), {59'd0, fw_addr_q[k]}, 64'(regs[k]));
      check_eq($sformatf("fill_wdata_k%0d", k), {32'd0, fw_data_q[k]}, 64'(32'hCAFE_0000 | 32'(regs[k])));
    end
    check_eq("fill_csr_cnt", 64'(csr_cnt), 64'd1);
    check_eq("fill_mcause", {32'd0, csr_mcause}, 64'h8000_0007);
    check_eq("fill_mepc", {32'd0, csr_mepc}, 64'h0000_0100);

    // Stalled bus: spill and refill with random grant/rvalid delays
    stall_en = 1'b1;
    mcause = 32'h8000_000B; mepc = 32'h0000_2000;
    clear_logs();
    do_req(1'b1, 1'b0, "stall_spill");
    check_eq("stall_spill_nwr", 64'(wr_addr_q.size()), 64'd9);
    mcause = 32'd0; mepc = 32'd0;
    clear_logs();
    do_req(1'b0, 1'b1, "stall_fill");
    check_eq("stall_fill_nwe", 64'(fw_addr_q.size()), 64'd7);
    if (fw_data_q.size() > 3) check_eq("stall_fill_x11", {32'd0, fw_data_q[3]}, 64'hCAFE_000B);
    check_eq("stall_fill_mcause", {32'd0, csr_mcause}, 64'h8000_000B);
    check_eq("stall_fill_mepc", {32'd0, csr_mepc}, 64'h0000_2000);
    stall_en = 1'b0;

    // Spill stack is empty again: the next exit is a plain decrement
    do_req(1'b0, 1'b1, "post_fill_exit");
    check_eq("post_fill_lat", 64'(lat), 64'd1);
    check_eq("post_fill_dec", 64'(n_dec), 64'd1);
    do_req(1'b1, 1'b0, "refill_hw");

    // Eight spills fill every memory slot
    for (int s = 0; s < 8; s++) begin
      mcause = 32'h8000_0000 + 32'(s);
      mepc   = 32'h0000_1000 + 32'(s);
      clear_logs();
      do_req(1'b1, 1'b0, "spill_n");
      check_eq($sformatf("spill%0d_lat", s), 64'(lat), 64'd19);
      exp_addr = 32'h0000_F000 + 32'(36 * s);
      if (wr_addr_q.size() > 0) check_eq($sformatf("spill%0d_base", s), {32'd0, wr_addr_q[0]}, {32'd0, exp_addr});
      else check_eq($sformatf("spill%0d_nwr", s), 64'd0, 64'd9);
    end

    // Overflow: entry with every slot used
    clear_logs();
    do_req(1'b1, 1'b0, "overflow");
    check_eq("ovf_lat", 64'(lat), 64'd1);
    check_eq("ovf_flag", {63'd0, overflow_err}, 64'd1);
    check_eq("ovf_save", 64'(n_save), 64'd1);
    check_eq("ovf_inc", 64'(n_inc), 64'd0);
    check_eq("ovf_no_bus", 64'(wr_addr_q.size()), 64'd0);

    // Entry and exit together: entry first, then the exit refills slot 7
    clear_logs();
    do_req(1'b1, 1'b1, "both_entry");
    check_eq("both_entry_lat", 64'(lat), 64'd1);
    check_eq("both_no_exit_ack", 64'(n_xack), 64'd0);
    do_req(1'b0, 1'b1, "both_exit");
    check_eq("both_exit_lat", 64'(lat), 64'd19);
    if (rd_addr_q.size() > 0) check_eq("both_fill_base", {32'd0, rd_addr_q[0]}, 64'h0000_F0FC);
    else check_eq("both_fill_nrd", 64'd0, 64'd9);
    check_eq("both_fill_mcause", {32'd0, csr_mcause}, 64'h8000_0007);
    check_eq("both_fill_mepc", {32'd0, csr_mepc}, 64'h0000_1007);

    // Reset while word 4 of a spill into slot 7 is on the bus
    mcause = 32'h8000_0009; mepc = 32'h0000_3000;
    @(negedge clk);
    entry_req = 1'b1;
    found = 1'b0;
    for (int n = 0; n < 100 && !found; n++) begin
      @(negedge clk);
      if (bus.data_req === 1'b1 && bus.data_addr === 32'h0000_F10C) found = 1'b1;
    end
    check_eq("rst_word4_seen", {63'd0, found}, 64'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_mid_req", {63'd0, bus.data_req}, 64'd0);
    check_eq("rst_mid_busy", {63'd0, busy}, 64'd0);
    entry_req = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check_eq("rst_mid_ovf", {63'd0, overflow_err}, 64'd0);
    do_req(1'b1, 1'b0, "after_rst");
    check_eq("after_rst_lat", 64'(lat), 64'd1);
    check_eq("after_rst_inc", 64'(n_inc), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
